// File: rtl/pipe_scroller.sv
// pipe_scroller: game-logic stage that scrolls three pipes left once per
// frame, respawns each at the right with a pseudo-random gap height, counts
// score as pipes pass the bird, and freezes on collision.
//
// Ports
//   clk_div                     system/pixel clock
//   rst_n                       asynchronous active-low reset
//   frame_tick                  one-cycle pulse per frame
//   start                       flap/start button (debounced level)
//   collision                   bird hit (level)
//   pipe1_x..pipe3_x    [9:0]   pipe left edge x
//   pipe1y_up..pipe3y_up[9:0]   bottom of upper pipe (gap is y_up..y_up+79)
//   score               [7:0]   pipes passed, saturating at 255
//   state               [1:0]   00 IDLE, 01 RUN, 10 HALT
//
// Optional build macro PIPE_SPEEDUP_EN: step grows with score
// (SPEED + min(score>>3, 3)). Without it the step is always SPEED.
//
// FSM states
//   state | meaning
//   IDLE  | pipes parked at restart positions, waiting for start
//   RUN   | scrolling on frame_tick, scoring, watching for collision
//   HALT  | frozen after collision, start returns to IDLE with a reload

module pipe_scroller #(
  parameter int          SPEED     = 2,
  parameter int          PERIOD    = 660,
  parameter int          PIPE1_X0  = 400,
  parameter int          GAP_MIN   = 40,
  parameter int          SCORE_X   = 60,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collision,
  output logic [9:0] pipe1_x,
  output logic [9:0] pipe2_x,
  output logic [9:0] pipe3_x,
  output logic [9:0] pipe1y_up,
  output logic [9:0] pipe2y_up,
  output logic [9:0] pipe3y_up,
  output logic [7:0] score,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [9:0] L_SPEED   = 10'(SPEED);
  localparam logic [9:0] L_PERIOD  = 10'(PERIOD);
  localparam logic [9:0] L_GAP_MIN = 10'(GAP_MIN);
  localparam logic [9:0] L_SCORE_X = 10'(SCORE_X);
  localparam logic [9:0] L_X1_0    = 10'(PIPE1_X0);
  localparam logic [9:0] L_X2_0    = 10'(PIPE1_X0 + PERIOD / 3);
  localparam logic [9:0] L_X3_0    = 10'(PIPE1_X0 + 2 * (PERIOD / 3));
  localparam logic [9:0] L_Y1_0    = 10'd200;
  localparam logic [9:0] L_Y2_0    = 10'd120;
  localparam logic [9:0] L_Y3_0    = 10'd280;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;
  logic [9:0]  r_x [3];
  logic [9:0]  r_y [3];
  logic [7:0]  r_score;

  logic        w_load;
  logic        w_move;
  logic [9:0]  w_step;
  logic [8:0]  w_r     [3];
  logic [8:0]  w_off   [3];
  logic [9:0]  w_gap   [3];
  logic        w_wrap  [3];
  logic [9:0]  w_x_mv  [3];
  logic        w_cross [3];
  logic [1:0]  w_ncross;
  logic [8:0]  w_sum;
  logic [7:0]  w_score_nxt;

  // Fibonacci LFSR, taps 16,14,13,11, shifting left into bit 0.
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

`ifdef PIPE_SPEEDUP_EN
  logic [1:0] w_bonus;
  // min(score>>3, 3): any of the top three score bits set means the cap
  assign w_bonus = (r_score[7:5] != 3'd0) ? 2'd3 : r_score[4:3];
  assign w_step  = L_SPEED + {8'd0, w_bonus};
`else
  assign w_step  = L_SPEED;
`endif

  // Each pipe draws its gap from a different overlapping 9-bit window
  assign w_r[0] = r_lfsr[8:0];
  assign w_r[1] = r_lfsr[12:4];
  assign w_r[2] = r_lfsr[15:7];

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_move      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // collision wins over a same-cycle frame_tick: nothing moves
        if (collision)       w_state_nxt = ST_HALT;
        else if (frame_tick) w_move      = 1'b1;
      end
      ST_HALT: begin
        if (start) begin
          w_state_nxt = ST_IDLE;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      // fold 320..511 down by 256 so gap bottom stays on screen
      w_off[i]   = (w_r[i] >= 9'd320) ? (w_r[i] - 9'd256) : w_r[i];
      w_gap[i]   = L_GAP_MIN + {1'b0, w_off[i]};
      w_wrap[i]  = (r_x[i] < w_step);
      w_x_mv[i]  = w_wrap[i] ? (r_x[i] + L_PERIOD - w_step) : (r_x[i] - w_step);
      w_cross[i] = (r_x[i] >= L_SCORE_X) && (w_x_mv[i] < L_SCORE_X);
    end
    w_ncross    = {1'b0, w_cross[0]} + {1'b0, w_cross[1]} + {1'b0, w_cross[2]};
    w_sum       = {1'b0, r_score} + {7'd0, w_ncross};
    w_score_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_x[0]  <= L_X1_0;
      r_x[1]  <= L_X2_0;
      r_x[2]  <= L_X3_0;
      r_y[0]  <= L_Y1_0;
      r_y[1]  <= L_Y2_0;
      r_y[2]  <= L_Y3_0;
      r_score <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      if (w_load) begin
        r_x[0]  <= L_X1_0;
        r_x[1]  <= L_X2_0;
        r_x[2]  <= L_X3_0;
        r_y[0]  <= L_Y1_0;
        r_y[1]  <= L_Y2_0;
        r_y[2]  <= L_Y3_0;
        r_score <= 8'd0;
      end else if (w_move) begin
        for (int i = 0; i < 3; i++) begin
          r_x[i] <= w_x_mv[i];
          if (w_wrap[i]) r_y[i] <= w_gap[i];
        end
        r_score <= w_score_nxt;
      end
    end
  end

  assign pipe1_x   = r_x[0];
  assign pipe2_x   = r_x[1];
  assign pipe3_x   = r_x[2];
  assign pipe1y_up = r_y[0];
  assign pipe2y_up = r_y[1];
  assign pipe3y_up = r_y[2];
  assign score     = r_score;
  assign state     = r_state;

endmodule

// File: tb/tb_pipe_scroller.sv
module tb_pipe_scroller;

  logic       clk_div = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic [9:0] pipe1_x, pipe2_x, pipe3_x;
  logic [9:0] pipe1y_up, pipe2y_up, pipe3y_up;
  logic [7:0] score;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk_div = ~clk_div;

  pipe_scroller dut (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .collision  (collision),
    .pipe1_x    (pipe1_x),
    .pipe2_x    (pipe2_x),
    .pipe3_x    (pipe3_x),
    .pipe1y_up  (pipe1y_up),
    .pipe2y_up  (pipe2y_up),
    .pipe3y_up  (pipe3y_up),
    .score      (score),
    .state      (state)
  );

  // Behavioural model: game state as plain integers
  int          m_state;   // 0 idle, 1 run, 2 halt
  int          m_x [3];
  int          m_y [3];
  int          m_score;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input logic [15:0] l, input int sh);
    int r;
    r = (int'(l) >> sh) % 512;
    if (r >= 320) r = r - 256;
    return 40 + r;
  endfunction

  function automatic int step_of(input int sc);
`ifdef PIPE_SPEEDUP_EN
    int b;
    b = sc / 8;
    if (b > 3) b = 3;
    return 2 + b;
`else
    return 2 + 0 * sc;
`endif
  endfunction

  task automatic model_positions();
    m_x[0] = 400; m_x[1] = 620; m_x[2] = 840;
    m_y[0] = 200; m_y[1] = 120; m_y[2] = 280;
    m_score = 0;
  endtask

  task automatic model_reset();
    m_state = 0;
    model_positions();
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    int st, pre, post, cnt;
    int sh [3];
    sh[0] = 0; sh[1] = 4; sh[2] = 7;
    case (m_state)
      0: if (start) m_state = 1;
      1: begin
        if (collision) m_state = 2;
        else if (frame_tick) begin
          st  = step_of(m_score);
          cnt = 0;
          for (int i = 0; i < 3; i++) begin
            pre = m_x[i];
            if (pre >= st) post = pre - st;
            else begin
              post   = pre + 660 - st;
              m_y[i] = gap_of(m_lfsr, sh[i]);
            end
            if (pre >= 60 && post < 60) cnt++;
            m_x[i] = post;
          end
          m_score = (m_score + cnt > 255) ? 255 : m_score + cnt;
        end
      end
      default: if (start) begin
        m_state = 0;
        model_positions();
      end
    endcase
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  endtask

  always @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk_div) begin
    if (chk_en && rst_n) begin
      check("state", int'(state), m_state);
      check("pipe1_x", int'(pipe1_x), m_x[0]);
      check("pipe2_x", int'(pipe2_x), m_x[1]);
      check("pipe3_x", int'(pipe3_x), m_x[2]);
      check("pipe1y_up", int'(pipe1y_up), m_y[0]);
      check("pipe2y_up", int'(pipe2y_up), m_y[1]);
      check("pipe3y_up", int'(pipe3y_up), m_y[2]);
      check("score", int'(score), m_score);
    end
  end

  task automatic tick();
    @(negedge clk_div);
    frame_tick = 1'b1;
    start      = 1'($urandom_range(0, 1));
    @(negedge clk_div);
    frame_tick = 1'b0;
    start      = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk_div);
  endtask

  task automatic check_restart(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_x1"}, int'(pipe1_x), 400);
    check({tag, "_x2"}, int'(pipe2_x), 620);
    check({tag, "_x3"}, int'(pipe3_x), 840);
    check({tag, "_y1"}, int'(pipe1y_up), 200);
    check({tag, "_y2"}, int'(pipe2y_up), 120);
    check({tag, "_y3"}, int'(pipe3y_up), 280);
    check({tag, "_score"}, int'(score), 0);
  endtask

  initial begin
    model_reset();
    #7;
    check_restart("reset");
    @(negedge clk_div);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // frame_tick while idle does nothing
    repeat (3) begin
      @(negedge clk_div);
      frame_tick = 1'b1;
    end
    @(negedge clk_div);
    frame_tick = 1'b0;
    check("idle_tick_x1", int'(pipe1_x), 400);

    @(negedge clk_div);
    start = 1'b1;
    @(negedge clk_div);
    start = 1'b0;
    check("run_state", int'(state), 1);

    for (int t = 1; t <= 201; t++) begin
      tick();
`ifndef PIPE_SPEEDUP_EN
      if (t == 1) begin
        check("t1_x1", int'(pipe1_x), 398);
        check("t1_x2", int'(pipe2_x), 618);
        check("t1_x3", int'(pipe3_x), 838);
      end
      if (t == 170) begin
        check("t170_x1", int'(pipe1_x), 60);
        check("t170_score", int'(score), 0);
      end
      if (t == 171) begin
        check("t171_x1", int'(pipe1_x), 58);
        check("t171_score", int'(score), 1);
      end
      if (t == 200) begin
        check("t200_x1", int'(pipe1_x), 0);
        check("t200_score", int'(score), 1);
      end
      if (t == 201) begin
        check("t201_x1", int'(pipe1_x), 658);
        check("t201_y1_range", int'(pipe1y_up >= 10'd40 && pipe1y_up <= 10'd359), 1);
        check("t201_y1_model", int'(pipe1y_up), m_y[0]);
      end
`endif
    end

    // collision together with frame_tick: freeze without moving
    @(negedge clk_div);
    collision  = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk_div);
    frame_tick = 1'b0;
    check("col_state", int'(state), 2);
`ifndef PIPE_SPEEDUP_EN
    check("col_x1", int'(pipe1_x), 658);
    check("col_x2", int'(pipe2_x), 218);
    check("col_x3", int'(pipe3_x), 438);
    check("col_score", int'(score), 1);
`endif
    collision = 1'b0;
    repeat (5) begin
      @(negedge clk_div);
      frame_tick = 1'b1;
      collision  = 1'($urandom_range(0, 1));
      @(negedge clk_div);
      frame_tick = 1'b0;
    end
    check("halt_state", int'(state), 2);
`ifndef PIPE_SPEEDUP_EN
    check("halt_x1", int'(pipe1_x), 658);
`endif
    @(negedge clk_div);
    collision = 1'b0;
    start     = 1'b1;
    @(negedge clk_div);
    start = 1'b0;
    check_restart("restart");

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_div);
      frame_tick = 1'($urandom_range(0, 1));
      start      = ($urandom_range(0, 29) == 0);
      collision  = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk_div);
    frame_tick = 1'b0;
    start      = 1'b0;
    collision  = 1'b0;

    // get to RUN (from any state) and play a little, then reset mid-run
    repeat (2) begin
      @(negedge clk_div);
      start = 1'b1;
      @(negedge clk_div);
      start = 1'b0;
    end
    if (state != 2'b01) begin
      @(negedge clk_div);
      start = 1'b1;
      @(negedge clk_div);
      start = 1'b0;
    end
    check("pre_reset_run", int'(state), 1);
    repeat (50) tick();
    @(negedge clk_div);
    #2 rst_n = 1'b0;
    #1 check_restart("midrun_reset");
    @(negedge clk_div);
    rst_n = 1'b1;

    // long run to saturate the score
    @(negedge clk_div);
    start = 1'b1;
    @(negedge clk_div);
    start      = 1'b0;
    frame_tick = 1'b1;
    repeat (29000) @(negedge clk_div);
    frame_tick = 1'b0;
    @(negedge clk_div);
    check("sat_score", int'(score), 255);
    check("sat_state", int'(state), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
